// File: rtl/cv32e40p_voter_pkg.sv
// cv32e40p_voter_pkg: shared voter mode encoding and counter sizing helper
package cv32e40p_voter_pkg;
  typedef enum logic [1:0] {
    VM_TMR  = 2'b00,
    VM_DMR  = 2'b01,
    VM_FAIL = 2'b10
  } voter_mode_e;
  function automatic int cons_cnt_w(input int thr);
    return $clog2(thr + 1);
  endfunction
endpackage

// File: rtl/cv32e40p_vote3_core.sv
// cv32e40p_vote3_core: combinational vote of one word triplet under the current mode
module cv32e40p_vote3_core
  import cv32e40p_voter_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] in_1,
  input  logic [LEN-1:0] in_2,
  input  logic [LEN-1:0] in_3,
  input  voter_mode_e    mode,
  input  logic [1:0]     excl,
  output logic [LEN-1:0] voted,
  output logic           corr,
  output logic           det,
  output logic [2:0]     odd
);
  logic e12, e13, e23;
  logic [LEN-1:0] da, db;
  assign e12 = in_1 == in_2;
  assign e13 = in_1 == in_3;
  assign e23 = in_2 == in_3;
  // surviving DMR pair, lower index first
  assign da = excl == 2'd0 ? in_2 : in_1;
  assign db = excl == 2'd2 ? in_2 : in_3;
  always_comb begin
    voted = in_1;
    corr  = 1'b0;
    det   = 1'b0;
    odd   = 3'b000;
    if (mode == VM_TMR) begin
      odd   = {e12 & ~e13, e13 & ~e12, e23 & ~e12};
      corr  = |odd;
      det   = ~(e12 & e13);
      voted = odd[0] ? in_2 : in_1;
    end else if (mode == VM_DMR) begin
      voted = da;
      det   = da != db;
    end else begin
      det = 1'b1;
    end
  end
endmodule

// File: rtl/cv32e40p_tmr_voter_monitor.sv
// cv32e40p_tmr_voter_monitor: registered TMR voter with fault tracking and TMR->DMR->FAIL degradation
module cv32e40p_tmr_voter_monitor
  import cv32e40p_voter_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int N_IN     = 2,
  parameter int PERM_THR = 4,
  parameter int CNT_W    = 8,
  parameter bit REG_OUT  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      valid_i,
  input  logic [N_IN-1:0][LEN-1:0]  in_1_i,
  input  logic [N_IN-1:0][LEN-1:0]  in_2_i,
  input  logic [N_IN-1:0][LEN-1:0]  in_3_i,
  output logic                      valid_o,
  output logic [N_IN-1:0][LEN-1:0]  voted_o,
  output logic [N_IN-1:0]           err_corrected_o,
  output logic [N_IN-1:0]           err_detected_o,
  output logic [1:0]                mode_o,
  output logic [2:0]                faulty_o,
  output logic                      fatal_o,
  output logic [CNT_W-1:0]          corr_cnt_o,
  output logic [CNT_W-1:0]          uncorr_cnt_o
);
  localparam int CW = cons_cnt_w(PERM_THR);
  localparam logic [CW-1:0] THR = CW'(PERM_THR);
  voter_mode_e mode_q, mode_d;
  logic [2:0] faulty_q, faulty_d, flag, hit;
  logic [2:0][CW-1:0] rc_q, rc_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] corr_q, unc_q;
  logic [N_IN-1:0][LEN-1:0] v;
  logic [N_IN-1:0] c, d;
  logic [N_IN-1:0][2:0] odd;
  logic [1:0] excl;
  assign excl = faulty_q[0] ? 2'd0 : faulty_q[1] ? 2'd1 : 2'd2;
  for (genvar g = 0; g < N_IN; g++) begin : g_core
    cv32e40p_vote3_core #(.LEN(LEN)) u_core (
      .in_1  (in_1_i[g]),
      .in_2  (in_2_i[g]),
      .in_3  (in_3_i[g]),
      .mode  (mode_q),
      .excl  (excl),
      .voted (v[g]),
      .corr  (c[g]),
      .det   (d[g]),
      .odd   (odd[g])
    );
  end
  always_comb begin
    flag = 3'b000;
    for (int k = 0; k < N_IN; k++) flag = flag | odd[k];
  end
  always_comb begin
    mode_d   = mode_q;
    faulty_d = faulty_q;
    rc_d     = rc_q;
    pc_d     = pc_q;
    hit      = 3'b000;
    if (valid_i && mode_q == VM_TMR) begin
      for (int r = 0; r < 3; r++) begin
        rc_d[r] = !flag[r] ? '0 : rc_q[r] == THR ? rc_q[r] : rc_q[r] + 1'b1;
        hit[r]  = rc_d[r] == THR;
      end
      if (|hit) begin
        faulty_d = faulty_q | hit;
        mode_d   = $onehot(hit) ? VM_DMR : VM_FAIL;
      end
    end else if (valid_i && mode_q == VM_DMR) begin
      pc_d = !(|d) ? '0 : pc_q == THR ? pc_q : pc_q + 1'b1;
      if (pc_d == THR) begin
        mode_d   = VM_FAIL;
        faulty_d = 3'b111;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear_i) begin
      mode_q   <= VM_TMR;
      faulty_q <= '0;
      rc_q     <= '0;
      pc_q     <= '0;
      corr_q   <= '0;
      unc_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      faulty_q <= faulty_d;
      rc_q     <= rc_d;
      pc_q     <= pc_d;
      if (valid_i && |c && corr_q != '1) corr_q <= corr_q + 1'b1;
      if (valid_i && |(d & ~c) && unc_q != '1) unc_q <= unc_q + 1'b1;
    end
  end
  if (REG_OUT) begin : g_reg
    logic vq;
    logic [N_IN-1:0][LEN-1:0] wq;
    logic [N_IN-1:0] cq, dq;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vq <= 1'b0;
        wq <= '0;
        cq <= '0;
        dq <= '0;
      end else begin
        vq <= valid_i;
        cq <= valid_i ? c : '0;
        dq <= valid_i ? d : '0;
        if (valid_i) wq <= v;
      end
    end
    assign valid_o         = vq;
    assign voted_o         = wq;
    assign err_corrected_o = cq;
    assign err_detected_o  = dq;
  end else begin : g_comb
    assign valid_o         = valid_i;
    assign voted_o         = v;
    assign err_corrected_o = valid_i ? c : '0;
    assign err_detected_o  = valid_i ? d : '0;
  end
  assign mode_o       = mode_q;
  assign faulty_o     = faulty_q;
  assign fatal_o      = mode_q == VM_FAIL;
  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = unc_q;
endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// tb_cv32e40p_tmr_voter_monitor: registered and combinational builds checked against a majority-vote model
module tb_cv32e40p_tmr_voter_monitor;
  localparam int LEN = 32;
  localparam int N = 2;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst, clr, vld;
  logic [N-1:0][LEN-1:0] in1, in2, in3;
  logic a_valid, a_fatal, b_valid, b_fatal;
  logic [N-1:0][LEN-1:0] a_voted, b_voted;
  logic [N-1:0] a_corr, a_det, b_corr, b_det;
  logic [1:0] a_mode, b_mode;
  logic [2:0] a_faulty, b_faulty;
  logic [7:0] a_cc, a_uc;
  logic [1:0] b_cc, b_uc;
  int checks = 0;
  int failures = 0;
  logic [1:0] m_mode;
  logic [2:0] m_faulty;
  int m_rc[3];
  int m_pc, m_cc, m_uc, m_cc2, m_uc2;
  logic [N-1:0][LEN-1:0] e_v;
  logic [N-1:0] e_c, e_d;
  logic [2:0] e_fl;

  always #5 clk = ~clk;

  cv32e40p_tmr_voter_monitor #(.LEN(LEN), .N_IN(N), .PERM_THR(T), .CNT_W(8), .REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .clear_i(clr), .valid_i(vld),
    .in_1_i(in1), .in_2_i(in2), .in_3_i(in3),
    .valid_o(a_valid), .voted_o(a_voted), .err_corrected_o(a_corr), .err_detected_o(a_det),
    .mode_o(a_mode), .faulty_o(a_faulty), .fatal_o(a_fatal),
    .corr_cnt_o(a_cc), .uncorr_cnt_o(a_uc)
  );
  cv32e40p_tmr_voter_monitor #(.LEN(LEN), .N_IN(N), .PERM_THR(T), .CNT_W(2), .REG_OUT(0)) u_comb (
    .clk(clk), .rst(rst), .clear_i(clr), .valid_i(vld),
    .in_1_i(in1), .in_2_i(in2), .in_3_i(in3),
    .valid_o(b_valid), .voted_o(b_voted), .err_corrected_o(b_corr), .err_detected_o(b_det),
    .mode_o(b_mode), .faulty_o(b_faulty), .fatal_o(b_fatal),
    .corr_cnt_o(b_cc), .uncorr_cnt_o(b_uc)
  );

  task automatic model_reset();
    m_mode = 2'd0; m_faulty = 3'b000; m_pc = 0;
    m_cc = 0; m_uc = 0; m_cc2 = 0; m_uc2 = 0;
    for (int r = 0; r < 3; r++) m_rc[r] = 0;
  endtask

  // value held by at least two replicas wins; the loner is flagged
  task automatic model_vote();
    logic [LEN-1:0] w[3];
    int ids[2];
    int n;
    bit found;
    e_v = '0; e_c = '0; e_d = '0; e_fl = 3'b000;
    for (int k = 0; k < N; k++) begin
      w[0] = in1[k]; w[1] = in2[k]; w[2] = in3[k];
      if (m_mode == 2'd0) begin
        e_v[k] = w[0];
        if (!(w[0] == w[1] && w[1] == w[2])) begin
          found = 0;
          for (int r = 0; r < 3; r++)
            if (w[(r+1)%3] == w[(r+2)%3]) begin
              e_v[k] = w[(r+1)%3]; e_c[k] = 1'b1; e_d[k] = 1'b1; e_fl[r] = 1'b1; found = 1;
            end
          if (!found) e_d[k] = 1'b1;
        end
      end else if (m_mode == 2'd1) begin
        n = 0;
        for (int r = 0; r < 3; r++) if (!m_faulty[r]) begin ids[n] = r; n++; end
        e_v[k] = w[ids[0]];
        e_d[k] = w[ids[0]] != w[ids[1]];
      end else begin
        e_v[k] = w[0]; e_d[k] = 1'b1;
      end
    end
    if (!vld) begin e_c = '0; e_d = '0; end
  endtask

  task automatic model_update(input logic v, input logic cl);
    int nhit;
    logic [2:0] h;
    if (cl) model_reset();
    else if (v) begin
      if (m_mode == 2'd0) begin
        nhit = 0; h = 3'b000;
        for (int r = 0; r < 3; r++) begin
          m_rc[r] = e_fl[r] ? (m_rc[r] + 1 > T ? T : m_rc[r] + 1) : 0;
          if (m_rc[r] == T) begin h[r] = 1'b1; nhit++; end
        end
        if (nhit > 0) begin m_faulty = m_faulty | h; m_mode = nhit == 1 ? 2'd1 : 2'd2; end
      end else if (m_mode == 2'd1) begin
        m_pc = |e_d ? (m_pc + 1 > T ? T : m_pc + 1) : 0;
        if (m_pc == T) begin m_mode = 2'd2; m_faulty = 3'b111; end
      end
      if (|e_c) begin
        m_cc = m_cc == 255 ? 255 : m_cc + 1;
        m_cc2 = m_cc2 == 3 ? 3 : m_cc2 + 1;
      end
      if (|(e_d & ~e_c)) begin
        m_uc = m_uc == 255 ? 255 : m_uc + 1;
        m_uc2 = m_uc2 == 3 ? 3 : m_uc2 + 1;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic cl, input logic [N-1:0][LEN-1:0] a,
                       input logic [N-1:0][LEN-1:0] b, input logic [N-1:0][LEN-1:0] c);
    @(negedge clk);
    vld = v; clr = cl; in1 = a; in2 = b; in3 = c;
    #1;
    model_vote();
    checks++;
    if ({b_valid, b_corr, b_det} !== {v, e_c, e_d}) begin
      failures++;
      $display("FAIL comb_flags t=%0t got v=%b c=%b d=%b exp v=%b c=%b d=%b", $time, b_valid, b_corr, b_det, v, e_c, e_d);
    end
    checks++;
    if (b_voted !== e_v) begin
      failures++;
      $display("FAIL comb_voted t=%0t got %h exp %h", $time, b_voted, e_v);
    end
    @(posedge clk);
    #1;
    model_update(v, cl);
    checks++;
    if ({a_valid, a_corr, a_det} !== {v, e_c, e_d}) begin
      failures++;
      $display("FAIL reg_flags t=%0t got v=%b c=%b d=%b exp v=%b c=%b d=%b", $time, a_valid, a_corr, a_det, v, e_c, e_d);
    end
    if (v) begin
      checks++;
      if (a_voted !== e_v) begin
        failures++;
        $display("FAIL reg_voted t=%0t got %h exp %h", $time, a_voted, e_v);
      end
    end
    checks++;
    if ({a_mode, a_faulty, a_fatal, a_cc, a_uc} !== {m_mode, m_faulty, m_mode == 2'd2, 8'(m_cc), 8'(m_uc)}) begin
      failures++;
      $display("FAIL reg_status t=%0t got mode=%0d faulty=%b fatal=%b cc=%0d uc=%0d exp mode=%0d faulty=%b cc=%0d uc=%0d",
               $time, a_mode, a_faulty, a_fatal, a_cc, a_uc, m_mode, m_faulty, m_cc, m_uc);
    end
    checks++;
    if ({b_mode, b_faulty, b_fatal, b_cc, b_uc} !== {m_mode, m_faulty, m_mode == 2'd2, 2'(m_cc2), 2'(m_uc2)}) begin
      failures++;
      $display("FAIL comb_status t=%0t got mode=%0d faulty=%b cc=%0d uc=%0d exp mode=%0d faulty=%b cc=%0d uc=%0d",
               $time, b_mode, b_faulty, b_cc, b_uc, m_mode, m_faulty, m_cc2, m_uc2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; vld = 1'b0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    #2;
    checks++;
    if ({a_valid, a_voted, a_corr, a_det, a_mode, a_faulty, a_fatal, a_cc, a_uc} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b mode=%0d faulty=%b cc=%0d uc=%0d exp all zero", a_valid, a_mode, a_faulty, a_cc, a_uc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    logic [N-1:0][LEN-1:0] a;
    a = {N{32'hA5A5A5A5}};
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, a, a, a);
    checks++;
    if ({a_voted, a_det, a_cc, a_mode} !== {{N{32'hA5A5A5A5}}, 2'b00, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL clean_stream got voted=%h det=%b cc=%0d mode=%0d exp a5a5a5a5 x2 det=0 cc=0 mode=0", a_voted, a_det, a_cc, a_mode);
    end
  endtask

  task automatic test_single_correction();
    logic [N-1:0][LEN-1:0] a, b;
    a = {N{32'hA5A5A5A5}};
    b = a; b[0] = 32'hFFFFFFFF;
    cycle(1'b1, 1'b0, a, b, a);
    checks++;
    if ({a_voted[0], a_corr, a_cc} !== {32'hA5A5A5A5, 2'b01, 8'd1}) begin
      failures++;
      $display("FAIL single_corr got voted0=%h corr=%b cc=%0d exp a5a5a5a5 01 1", a_voted[0], a_corr, a_cc);
    end
    cycle(1'b1, 1'b0, a, a, a);
    checks++;
    if (a_mode !== 2'd0) begin
      failures++;
      $display("FAIL single_no_degrade got mode=%0d exp 0", a_mode);
    end
  endtask

  task automatic test_dmr_degrade();
    logic [N-1:0][LEN-1:0] a, c;
    a = {N{32'h12345678}};
    c = a; c[1] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, a, a, c);
      if (i == 1) cycle(1'b0, 1'b0, a, a, c);
    end
    checks++;
    if ({a_mode, a_faulty, a_corr, a_voted[1]} !== {2'd1, 3'b100, 2'b10, 32'h12345678}) begin
      failures++;
      $display("FAIL dmr_entry got mode=%0d faulty=%b corr=%b voted1=%h exp 1 100 10 12345678", a_mode, a_faulty, a_corr, a_voted[1]);
    end
  endtask

  task automatic test_fail();
    logic [N-1:0][LEN-1:0] a, b, c;
    a = {N{32'd1}}; b = {N{32'd2}}; c = {N{32'd3}};
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, a, b, c);
    checks++;
    if ({a_mode, a_fatal, a_faulty, a_det, a_corr, a_uc} !== {2'd2, 1'b1, 3'b111, 2'b11, 2'b00, 8'd4}) begin
      failures++;
      $display("FAIL dmr_to_fail got mode=%0d fatal=%b faulty=%b det=%b corr=%b uc=%0d exp 2 1 111 11 00 4",
               a_mode, a_fatal, a_faulty, a_det, a_corr, a_uc);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, a, a, a);
    cycle(1'b1, 1'b1, a, a, a);
    checks++;
    if ({a_mode, a_faulty, a_uc} !== {2'd0, 3'b000, 8'd0}) begin
      failures++;
      $display("FAIL fail_clear got mode=%0d faulty=%b uc=%0d exp 0 000 0", a_mode, a_faulty, a_uc);
    end
  endtask

  task automatic test_saturation_clear();
    logic [N-1:0][LEN-1:0] a, o, w1, w2, w3;
    a = {N{32'hCAFEF00D}};
    o = {N{32'h00000000}};
    for (int i = 0; i < 260; i++) begin
      w1 = i % 3 == 0 ? o : a;
      w2 = i % 3 == 1 ? o : a;
      w3 = i % 3 == 2 ? o : a;
      cycle(1'b1, 1'b0, w1, w2, w3);
    end
    checks++;
    if ({a_cc, b_cc, a_mode} !== {8'd255, 2'd3, 2'd0}) begin
      failures++;
      $display("FAIL counter_saturate got cc=%0d cc2=%0d mode=%0d exp 255 3 0", a_cc, b_cc, a_mode);
    end
    cycle(1'b1, 1'b1, o, a, a);
    checks++;
    if ({a_corr, a_cc, b_cc} !== {2'b11, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL clear_wins got corr=%b cc=%0d cc2=%0d exp 11 0 0", a_corr, a_cc, b_cc);
    end
  endtask

  task automatic test_random();
    logic [N-1:0][LEN-1:0] w1, w2, w3;
    logic [LEN-1:0] base;
    int p;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        base = $urandom;
        w1[k] = base; w2[k] = base; w3[k] = base;
        p = $urandom_range(0, 9);
        if (p == 6) w1[k] = base ^ ($urandom | 32'd1);
        if (p == 7) w2[k] = base ^ ($urandom | 32'd1);
        if (p == 8) w3[k] = base ^ ($urandom | 32'd1);
        if (p == 9) begin w2[k] = base ^ 32'h1; w3[k] = base ^ 32'h2; end
      end
      cycle($urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0, w1, w2, w3);
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0][LEN-1:0] a, b;
    a = {N{32'h5A5A0F0F}};
    b = a; b[0] = 32'h0;
    cycle(1'b1, 1'b0, a, b, a);
    @(negedge clk);
    vld = 1'b1; in1 = a; in2 = a; in3 = a;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_valid, a_voted, a_corr, a_det, a_mode, a_faulty, a_fatal, a_cc, a_uc} !== '0) begin
      failures++;
      $display("FAIL async_reset got valid=%b voted=%h mode=%0d faulty=%b cc=%0d exp all zero", a_valid, a_voted, a_mode, a_faulty, a_cc);
    end
    checks++;
    if ({b_mode, b_faulty, b_cc, b_uc, b_voted} !== {2'd0, 3'b000, 2'd0, 2'd0, a}) begin
      failures++;
      $display("FAIL async_reset_comb got mode=%0d cc=%0d voted=%h exp 0 0 %h", b_mode, b_cc, b_voted, a);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, a, b, a);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_correction();
    test_dmr_degrade();
    test_fail();
    test_saturation_clear();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cv32e40p_tmr_voter_monitor.md
Name: cv32e40p_tmr_voter_monitor

Overview:
Registered, stateful successor of the combinational 3-way word voter. It votes N_IN triplets of LEN-bit replica outputs each valid cycle and tracks which replica repeatedly disagrees. After PERM_THR consecutive faults it excludes that replica permanently and degrades TMR -> DMR -> FAIL. It sits between the replicated pipeline stages and downstream consumers, and also feeds saturating error counters to the fault-status CSR logic.

Parameters:
LEN, 32, bit width of each voted word
N_IN, 2, number of input triplets voted in parallel
PERM_THR, 4, consecutive faulty valid samples before a replica (or the DMR pair) is declared permanently faulty; >=1
CNT_W, 8, width of saturating event counters
REG_OUT, 1, 1 = voted outputs registered (1-cycle latency); 0 = combinational outputs (status always registered)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clear_i  in  1  synchronous clear of mode, faulty flags and all counters
valid_i  in  1  triplet inputs valid this cycle
in_1_i  in  N_IN x LEN  replica 1 words
in_2_i  in  N_IN x LEN  replica 2 words
in_3_i  in  N_IN x LEN  replica 3 words
valid_o  out  1  voted outputs valid
voted_o  out  N_IN x LEN  voted words
err_corrected_o  out  N_IN  triplet k corrected
err_detected_o  out  N_IN  triplet k erroneous (corrected or not)
mode_o  out  2  current voter_mode_e
faulty_o  out  3  sticky per-replica permanent-fault flags
fatal_o  out  1  mode == VM_FAIL
corr_cnt_o  out  CNT_W  valid samples with >=1 corrected triplet, saturating
uncorr_cnt_o  out  CNT_W  valid samples with >=1 detected-uncorrected triplet, saturating

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, on port rst; clock port is clk.
- Reset values: every output is 0 and mode_o = VM_TMR (2'b00).
- Per-triplet vote in VM_TMR:
  - all equal -> out = in_1, corr = 0, det = 0.
  - exactly one odd -> out = majority, corr = 1, det = 1, odd replica flagged.
  - all different -> out = in_1, corr = 0, det = 1, no replica flagged.
- VM_DMR (excluded replica x = the faulty_o bit set): compare the two remaining replicas a < b.
  - equal -> out = in_a, no error.
  - differ -> out = in_a, corr = 0, det = 1.
- VM_FAIL: out = in_1, det = 1 for all k when valid, corr = 0.
- Only valid_i samples update state. Invalid cycles hold all counters and state; err outputs are 0 when the output valid is 0.
- Per-replica consecutive counter (range 0..PERM_THR), TMR only:
  - incremented (saturating) on a valid sample where the replica is flagged in any triplet.
  - cleared on a valid sample where it is flagged in no triplet.
- Mode FSM, updated at the edge that captures the sample:
  - TMR -> DMR when exactly one replica counter reaches PERM_THR; its faulty_o bit is set.
  - TMR -> FAIL if two or more reach PERM_THR in the same sample; their faulty_o bits are set.
  - DMR: a pair-mismatch counter increments on mismatching valid samples and clears on matching ones. At PERM_THR -> FAIL and all faulty_o bits are set.
  - FAIL is absorbing until clear_i or rst.
- The sample that triggers a transition is voted with the old mode; the new mode applies from the next sample.
- corr_cnt / uncorr_cnt: +1 per valid sample (not per triplet), saturate at 2^CNT_W-1, no wrap.
- clear_i: next cycle mode = TMR, faulty = 0, all counters = 0. Clear wins over a simultaneous event. The vote of a sample coinciding with clear_i is still output normally but is not counted.
- REG_OUT = 1: valid_o/voted_o/err_* are registered, 1-cycle latency, with a new sample every cycle (no backpressure). REG_OUT = 0: valid_o = valid_i, outputs combinational.
- rst mid-operation: immediate return to reset values and any in-flight registered sample is dropped.

Decomposition:
- Package cv32e40p_voter_pkg:
  - voter_mode_e {VM_TMR = 2'b00, VM_DMR = 2'b01, VM_FAIL = 2'b10}.
  - localparam helper for the consecutive-counter width, $clog2(PERM_THR+1).
- Sub-module cv32e40p_vote3_core (combinational, one per triplet, generate loop):
  - inputs: three words, mode, excluded index.
  - outputs: voted word, corr, det, 3-bit odd-replica flag.
- The top level holds the FSM, counters and output register.

Test Plan:
- N_IN=2, all replicas 0xA5A5A5A5, valid 10 cycles -> voted 0xA5A5A5A5 one cycle later, det = 0, counters 0, mode TMR.
- Triplet 0 in_2 = 0xFFFFFFFF once -> voted 0xA5A5A5A5, corr_o = 2'b01, corr_cnt 1; rep2 counter is reset by the next clean sample, so no mode change.
- PERM_THR=4, in_3 odd for 4 consecutive valid samples (an invalid cycle inserted between) -> mode DMR, faulty_o = 3'b100 after the 4th sample; the 4th sample is still corrected.
- In DMR, in_1 = 1 vs in_2 = 2 for 4 valid samples -> det = 1, corr = 0, uncorr_cnt 4, then mode FAIL, fatal_o = 1, faulty_o = 3'b111.
- CNT_W=2, 5 corrected samples -> corr_cnt_o saturates at 3; clear_i asserted with a corrected sample -> all counters 0, mode TMR next cycle.
- rst asserted mid-stream between edges -> outputs 0 immediately, mode TMR; REG_OUT=0 build: voted_o follows inputs in the same cycle.
